// File: rtl/hazard_pkg.sv
// ============================================================================
// Module      : hazard_pkg
// Description : Forward-select encodings and shared defaults for the
//               superscalar hazard unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

    // Source field of a forward select; the lane index sits above these bits.
    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_NONE = 2'b00;
    localparam fwd_sel_t FWD_M    = 2'b10;
    localparam fwd_sel_t FWD_W    = 2'b01;

    localparam int ECALL_REG_DEF = 10;

endpackage

`default_nettype wire

// File: rtl/fwd_sel.sv
// ============================================================================
// Module      : fwd_sel
// Description : Forward-select for one E-stage source operand across all
//               M/W lanes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_sel
    import hazard_pkg::*;
#(
    parameter int LANES = 2,
    parameter int LW    = 1
) (
    input  logic [4:0]             i_rs,
    input  logic [LANES-1:0][4:0]  i_rdM,
    input  logic [LANES-1:0]       i_regWriteM,
    input  logic [LANES-1:0][4:0]  i_rdW,
    input  logic [LANES-1:0]       i_regWriteW,
    output logic [LW+1:0]          o_sel
);

    // Later assignments override earlier ones: W is scanned first so any M
    // hit wins, and ascending lane order lets the highest lane win.
    always_comb begin
        o_sel = {{LW{1'b0}}, FWD_NONE};
        if (i_rs != 5'd0) begin
            for (int l = 0; l < LANES; l++) begin
                if (i_regWriteW[l] && (i_rdW[l] == i_rs)) begin
                    o_sel = {LW'(l), FWD_W};
                end
            end
            for (int l = 0; l < LANES; l++) begin
                if (i_regWriteM[l] && (i_rdM[l] == i_rs)) begin
                    o_sel = {LW'(l), FWD_M};
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/hazard_unit_ss.sv
// ============================================================================
// Module      : hazard_unit_ss
// Description : Superscalar hazard unit: forwarding, load/ecall/scoreboard/
//               structural hazards, stalls, flushes and stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_unit_ss
    import hazard_pkg::*;
#(
    parameter int LANES     = 2,
    parameter int NREG      = 32,
    parameter int ECALL_REG = ECALL_REG_DEF,
    parameter int LW        = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      IF_miss,
    input  logic [LANES-1:0]          Stall_miss,
    input  logic                      enableD,
    input  logic [LANES-1:0]          PCSrcE,
    input  logic [LANES-1:0][4:0]     Rs1D,
    input  logic [LANES-1:0][4:0]     Rs2D,
    input  logic [LANES-1:0][4:0]     Rs1E,
    input  logic [LANES-1:0][4:0]     Rs2E,
    input  logic [LANES-1:0][4:0]     RdE,
    input  logic [LANES-1:0]          ResultSrcE0,
    input  logic [LANES-1:0]          LongE,
    input  logic [LANES-1:0]          EcallE,
    input  logic [LANES-1:0]          EcallM,
    input  logic [LANES-1:0][4:0]     RdM,
    input  logic [LANES-1:0][4:0]     RdW,
    input  logic [LANES-1:0]          RegWriteM,
    input  logic [LANES-1:0]          RegWriteW,
    input  logic                      LongDone,
    input  logic [4:0]                LongRd,
    output logic                      StallF,
    output logic                      StallD,
    output logic                      StallE,
    output logic                      StallM,
    output logic                      StallW,
    output logic                      FlushD,
    output logic                      FlushE,
    output logic [LANES-1:0][LW+1:0]  ForwardAE,
    output logic [LANES-1:0][LW+1:0]  ForwardBE,
    output logic [31:0]               StallCnt
);

    logic [NREG-1:0] r_pending;
    logic [NREG-1:0] w_pendingEff;
    logic [NREG-1:0] w_pendingNext;
    logic [31:0]     r_stallCnt;

    logic w_memStall;
    logic w_redirect;
    logic w_loadHit;
    logic w_ecallSrc;
    logic w_sbHit;
    logic w_loadHazard;
    logic w_ecallHazard;
    logic w_sbHazard;
    logic w_structHazard;
    logic w_stallFD;
    logic w_stallE;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        fwd_sel #(.LANES(LANES), .LW(LW)) u_fwdA (
            .i_rs        (Rs1E[l]),
            .i_rdM       (RdM),
            .i_regWriteM (RegWriteM),
            .i_rdW       (RdW),
            .i_regWriteW (RegWriteW),
            .o_sel       (ForwardAE[l])
        );
        fwd_sel #(.LANES(LANES), .LW(LW)) u_fwdB (
            .i_rs        (Rs2E[l]),
            .i_rdM       (RdM),
            .i_regWriteM (RegWriteM),
            .i_rdW       (RdW),
            .i_regWriteW (RegWriteW),
            .o_sel       (ForwardBE[l])
        );
    end

    // The scoreboard reads as empty while reset is held.
    assign w_pendingEff = reset ? '0 : r_pending;

    assign w_memStall = IF_miss | (|Stall_miss);
    assign w_redirect = |PCSrcE;

    always_comb begin
        w_loadHit  = 1'b0;
        w_ecallSrc = 1'b0;
        w_sbHit    = 1'b0;
        for (int d = 0; d < LANES; d++) begin
            for (int e = 0; e < LANES; e++) begin
                if ((ResultSrcE0[e] || LongE[e]) && (RdE[e] != 5'd0) &&
                    ((Rs1D[d] == RdE[e]) || (Rs2D[d] == RdE[e]))) begin
                    w_loadHit = 1'b1;
                end
            end
            if ((Rs1D[d] == 5'(ECALL_REG)) || (Rs2D[d] == 5'(ECALL_REG))) begin
                w_ecallSrc = 1'b1;
            end
            for (int r = 1; r < NREG; r++) begin
                if (w_pendingEff[r] &&
                    ((Rs1D[d] == 5'(r)) || (Rs2D[d] == 5'(r)))) begin
                    w_sbHit = 1'b1;
                end
            end
        end
    end

    assign w_loadHazard   = enableD & w_loadHit;
    assign w_ecallHazard  = enableD & w_ecallSrc & ((|EcallE) | (|EcallM));
    assign w_sbHazard     = enableD & w_sbHit;
    // The mul/div unit holds one op at a time; a new one waits in E.
    assign w_structHazard = enableD & (|LongE) & (|w_pendingEff);

    assign w_stallFD = w_memStall | w_loadHazard | w_ecallHazard |
                       w_sbHazard | w_structHazard;
    assign w_stallE  = w_memStall | w_structHazard;

    // Clear first, then set, so a coincident set of the same register wins.
    always_comb begin
        w_pendingNext = r_pending;
        if (LongDone) begin
            for (int r = 0; r < NREG; r++) begin
                if (LongRd == 5'(r)) begin
                    w_pendingNext[r] = 1'b0;
                end
            end
        end
        if (!w_stallE) begin
            for (int l = 0; l < LANES; l++) begin
                for (int r = 1; r < NREG; r++) begin
                    if (LongE[l] && (RdE[l] == 5'(r))) begin
                        w_pendingNext[r] = 1'b1;
                    end
                end
            end
        end
        w_pendingNext[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending  <= '0;
            r_stallCnt <= '0;
        end else begin
            r_pending <= w_pendingNext;
            if (w_stallFD && (r_stallCnt != 32'hFFFF_FFFF)) begin
                r_stallCnt <= r_stallCnt + 32'd1;
            end
        end
    end

    assign StallF   = w_stallFD;
    assign StallD   = w_stallFD;
    assign StallE   = w_stallE;
    assign StallM   = w_memStall;
    assign StallW   = w_memStall;
    assign FlushD   = ~w_memStall & w_redirect;
    assign FlushE   = ~w_memStall & ~w_structHazard &
                      (w_redirect | w_loadHazard | w_ecallHazard | w_sbHazard);
    assign StallCnt = r_stallCnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit_ss.sv
// ============================================================================
// Module      : tb_hazard_unit_ss
// Description : Directed self-checking bench for hazard_unit_ss (LANES=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_unit_ss;

    localparam int LANES = 2;
    localparam int LW    = 1;

    logic                     clk;
    logic                     reset;
    logic                     IF_miss;
    logic [LANES-1:0]         Stall_miss;
    logic                     enableD;
    logic [LANES-1:0]         PCSrcE;
    logic [LANES-1:0][4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [LANES-1:0]         ResultSrcE0, LongE, EcallE, EcallM;
    logic [LANES-1:0]         RegWriteM, RegWriteW;
    logic                     LongDone;
    logic [4:0]               LongRd;
    logic                     StallF, StallD, StallE, StallM, StallW;
    logic                     FlushD, FlushE;
    logic [LANES-1:0][LW+1:0] ForwardAE, ForwardBE;
    logic [31:0]              StallCnt;

    int nVec;
    int nErr;
    int expCnt;
    bit stallNow;

    hazard_unit_ss #(.LANES(LANES), .NREG(32), .ECALL_REG(10)) dut (
        .clk         (clk),
        .reset       (reset),
        .IF_miss     (IF_miss),
        .Stall_miss  (Stall_miss),
        .enableD     (enableD),
        .PCSrcE      (PCSrcE),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .Rs1E        (Rs1E),
        .Rs2E        (Rs2E),
        .RdE         (RdE),
        .ResultSrcE0 (ResultSrcE0),
        .LongE       (LongE),
        .EcallE      (EcallE),
        .EcallM      (EcallM),
        .RdM         (RdM),
        .RdW         (RdW),
        .RegWriteM   (RegWriteM),
        .RegWriteW   (RegWriteW),
        .LongDone    (LongDone),
        .LongRd      (LongRd),
        .StallF      (StallF),
        .StallD      (StallD),
        .StallE      (StallE),
        .StallM      (StallM),
        .StallW      (StallW),
        .FlushD      (FlushD),
        .FlushE      (FlushE),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .StallCnt    (StallCnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        if (obs !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Control bundle {StallF,StallD,StallE,StallM,StallW,FlushD,FlushE}.
    task automatic chkCtl(input string tag, input logic [6:0] exp);
        #1;
        check(tag, {25'd0, StallF, StallD, StallE, StallM, StallW, FlushD, FlushE},
              {25'd0, exp});
        stallNow = exp[6];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (stallNow) expCnt++;
        stallNow = 1'b0;
    endtask

    task automatic clr();
        IF_miss = 0; Stall_miss = '0; enableD = 0; PCSrcE = '0;
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
        ResultSrcE0 = '0; LongE = '0; EcallE = '0; EcallM = '0;
        RegWriteM = '0; RegWriteW = '0; LongDone = 0; LongRd = '0;
    endtask

    initial begin
        nVec = 0; nErr = 0; expCnt = 0; stallNow = 0;
        clr();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chkCtl("reset_ctl", 7'b0000000);
        check("reset_cnt", StallCnt, 32'd0);
        check("reset_fwdA", {28'd0, ForwardAE}, 32'd0);

        // Forward priority
        Rs1E[0] = 5; RdM[0] = 5; RdM[1] = 5; RdW[1] = 5;
        RegWriteM = 2'b11; RegWriteW = 2'b11;
        #1; check("fwd_M_lane1", {29'd0, ForwardAE[0]}, 32'b110);
        RegWriteM[1] = 0;
        #1; check("fwd_M_lane0", {29'd0, ForwardAE[0]}, 32'b010);
        RegWriteM = 2'b00;
        #1; check("fwd_W_lane1", {29'd0, ForwardAE[0]}, 32'b101);
        RdW[1] = 6; RdW[0] = 5;
        #1; check("fwd_W_lane0", {29'd0, ForwardAE[0]}, 32'b001);
        Rs2E[1] = 6;
        #1; check("fwd_B_W_lane1", {29'd0, ForwardBE[1]}, 32'b101);
        clr(); RegWriteM = 2'b11; RegWriteW = 2'b11;
        #1; check("fwd_x0_none", {26'd0, ForwardAE, ForwardBE}, 32'd0);

        // Load-use
        clr();
        ResultSrcE0[1] = 1; RdE[1] = 7; Rs2D[0] = 7; enableD = 1;
        chkCtl("load_use", 7'b1100001);
        tick();
        clr();
        chkCtl("load_cleared", 7'b0000000);
        check("cnt_after_load", StallCnt, expCnt);
        ResultSrcE0[0] = 1; RdE[0] = 0; enableD = 1;
        chkCtl("load_rd0", 7'b0000000);

        // Scoreboard
        clr();
        LongE[0] = 1; RdE[0] = 9;
        chkCtl("long_issue", 7'b0000000);
        tick();
        clr();
        repeat (5) tick();
        Rs1D[1] = 9; enableD = 1;
        chkCtl("sb_hazard", 7'b1100001);
        tick();
        chkCtl("sb_hold", 7'b1100001);
        tick();
        LongE[1] = 1; RdE[1] = 12;
        chkCtl("struct_hazard", 7'b1110000);
        tick();
        LongDone = 1; LongRd = 9;
        chkCtl("struct_done_cyc", 7'b1110000);
        tick();
        LongDone = 0;
        chkCtl("sb_released", 7'b0000000);
        tick();
        clr();
        Rs1D[0] = 12; enableD = 1;
        chkCtl("sb_second", 7'b1100001);
        LongDone = 1; LongRd = 12;
        chkCtl("sb_second_done", 7'b1100001);
        tick();
        LongDone = 0;
        chkCtl("sb_second_clr", 7'b0000000);

        // Set/clear collision
        clr();
        LongE[0] = 1; RdE[0] = 4; LongDone = 1; LongRd = 4;
        chkCtl("collide_cyc", 7'b0000000);
        tick();
        clr();
        Rs1D[0] = 4; enableD = 1;
        chkCtl("collide_set_wins", 7'b1100001);

        // Ecall
        clr();
        Rs2D[1] = 10; enableD = 1; EcallM[0] = 1;
        chkCtl("ecall_hazard", 7'b1100001);
        Rs2D[1] = 11;
        chkCtl("ecall_other_reg", 7'b0000000);

        // Memory-stall masking
        clr();
        PCSrcE[0] = 1; Stall_miss[1] = 1;
        chkCtl("mem_mask", 7'b1111100);
        tick();
        Stall_miss = '0;
        chkCtl("redirect", 7'b0000011);

        // Reset mid-operation
        clr();
        LongE[0] = 1; RdE[0] = 9;
        chkCtl("pend9_issue", 7'b0000000);
        tick();
        clr();
        IF_miss = 1;
        while (expCnt < 100) begin
            stallNow = 1'b1;
            tick();
        end
        IF_miss = 0;
        check("cnt_100", StallCnt, 32'd100);
        Rs1D[0] = 9; Rs2D[1] = 4; enableD = 1;
        chkCtl("pend_before_rst", 7'b1100001);
        reset = 1;
        LongE[1] = 1; RdE[1] = 20; LongDone = 1; LongRd = 9;
        chkCtl("during_reset", 7'b0000000);
        tick();
        reset = 0;
        LongE = '0; RdE = '0; LongDone = 0;
        check("cnt_after_rst", StallCnt, 32'd0);
        chkCtl("pend_cleared", 7'b0000000);
        Rs1D[0] = 20; Rs2D[1] = 0;
        chkCtl("no_set_in_rst", 7'b0000000);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_unit_ss.md
HAZARD_UNIT_SS -- requirements
Module: hazard_unit_ss

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have the following parameters:
- LANES, 2: superscalar issue width, valid range 1..4.
- NREG, 32: architectural register count.
- ECALL_REG, 10: register read by ecall.
- LW, max(1,$clog2(LANES)): lane index width (derived).

Ports (name, direction, width, meaning):
REQ-002 The block SHALL have the following ports:
- clk, in, 1: the single clock.
- reset, in, 1: synchronous, active-high reset.
- IF_miss, in, 1: fetch miss wait.
- Stall_miss, in, LANES: per-lane AXI memory wait.
- enableD, in, 1: decode bundle valid.
- PCSrcE, in, LANES: branch/jump taken in E.
- Rs1D, Rs2D, in, LANES x 5: decode sources.
- Rs1E, Rs2E, RdE, in, LANES x 5: execute-stage register numbers.
- ResultSrcE0, in, LANES: E-stage op is a load.
- LongE, in, LANES: E-stage op issues to the multi-cycle mul/div unit.
- EcallE, EcallM, in, LANES: ecall present in E / M.
- RdM, RdW, in, LANES x 5: destination registers in M / W.
- RegWriteM, RegWriteW, in, LANES: register-write enables in M / W.
- LongDone, in, 1: mul/div writeback this cycle.
- LongRd, in, 5: mul/div destination register.
- StallF, StallD, StallE, StallM, StallW, out, 1 each: stage stalls.
- FlushD, FlushE, out, 1 each: stage flushes.
- ForwardAE, ForwardBE, out, LANES x (LW+2): forward selects.
- StallCnt, out, 32: saturating stall-cycle counter.

Function
REQ-003 Forward encoding SHALL be {lane[LW-1:0], src[1:0]}, with src 00=regfile, 10=M, 01=W; for LANES=2 it is bit-compatible with the 2-lane encoding (110=M lane1, 010=M lane0, 101=W lane1, 001=W lane0).
REQ-004 Forward priority per source SHALL be: M before W; within a stage, the highest lane index wins; source register 0 never forwards.
REQ-005 memStall SHALL equal IF_miss | OR(Stall_miss).
REQ-006 loadHazard SHALL be asserted when enableD and any D source equals RdE[l] of a lane with ResultSrcE0[l] or LongE[l], with RdE[l]!=0.
REQ-007 ecallHazard SHALL be asserted when enableD and any D source equals ECALL_REG while any EcallE or EcallM bit is set.
REQ-008 The block SHALL hold a pending[NREG] scoreboard; bit r is set on a cycle with !StallE and LongE[l] and RdE[l]==r!=0.
REQ-009 Scoreboard bit LongRd SHALL clear on a LongDone cycle; if a set and a clear of the same register coincide, the set SHALL win.
REQ-010 sbHazard SHALL be asserted when enableD and any D source has its pending bit set; pending[0] SHALL always read 0.
REQ-011 structHazard SHALL be asserted when enableD and a lane in E has LongE while any pending bit is set, because the mul/div unit accepts one outstanding op; this stall is applied at E: StallE=StallF=StallD=1, and FlushE is not asserted.
REQ-012 StallF and StallD SHALL equal memStall | loadHazard | ecallHazard | sbHazard | structHazard.
REQ-013 StallE SHALL equal memStall | structHazard.
REQ-014 StallM and StallW SHALL equal memStall.
REQ-015 FlushD SHALL equal !memStall & OR(PCSrcE).
REQ-016 FlushE SHALL equal !memStall & !structHazard & (OR(PCSrcE) | loadHazard | ecallHazard | sbHazard).
REQ-017 On a redirect with !StallE, the scoreboard SHALL NOT be set for lanes whose instruction is being flushed; set only occurs on E-leave.
REQ-018 StallCnt SHALL increment every cycle in which StallF=1 and saturate at 0xFFFFFFFF.
REQ-019 All hazard and forward outputs SHALL be combinational, with zero-cycle latency; the scoreboard and counter SHALL update on the clk rising edge.

Reset
REQ-020 On reset, pending SHALL clear to all-zero and StallCnt SHALL clear to 0 on the next clk edge.
REQ-021 During reset, the outputs SHALL reflect cleared state (no sbHazard, no structHazard).
REQ-022 A LongDone arriving in the reset cycle SHALL be ignored.

Structure
REQ-023 Shared package hazard_pkg SHALL hold the FWD_NONE/FWD_M/FWD_W constants, the fwd_sel_t typedef, and ECALL_REG_DEF.
REQ-024 A single sub-module fwd_sel SHALL be instantiated 2xLANES times, computing one source's forward select.
REQ-025 The scoreboard SHALL be implemented inline.

Verification
REQ-026 Forward priority: LANES=2, Rs1E[0]=5, RdM[0]=RdM[1]=RdW[1]=5, all RegWrite=1 -> ForwardAE[0]=3'b110; drop RegWriteM[1] -> 3'b010.
REQ-027 Load-use: ResultSrcE0[1]=1, RdE[1]=7, Rs2D[0]=7, enableD=1 -> StallF=StallD=FlushE=1, StallE=0; next cycle with the hazard cleared -> all zero.
REQ-028 Scoreboard: LongE[0], RdE=9 leaves E; 6 cycles later Rs1D[1]=9 -> StallD=1 until a LongDone/LongRd=9 cycle, after which StallD=0; a second LongE issued meanwhile -> StallE=1, FlushE=0.
REQ-029 Set/clear collision: LongDone with LongRd=4 in the same cycle as LongE with RdE=4 leaving -> pending[4]=1 afterwards.
REQ-030 Memory-stall masking: PCSrcE[0]=1 with Stall_miss[1]=1 -> FlushD=FlushE=0 and all stalls 1; release the miss -> FlushD=FlushE=1.
REQ-031 Reset mid-operation: pending={4,9}, StallCnt=100, reset for 1 cycle -> pending=0, StallCnt=0, sbHazard=0.
